// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/issue sequencer driving the datapath control FSM via s/w handshake.
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state after each retired instruction.
module instr_sequencer #(
   parameter int ADDR_W = 8,
   parameter int INSTR_W = 16,
   parameter logic [2:0] HALT_OPCODE = 3'b111
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic [INSTR_W-1:0] mem_data,
   input  logic               w,
`ifdef SINGLE_STEP_EN
   input  logic               step,
`endif
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd,
   output logic [INSTR_W-1:0] ir,
   output logic               s,
   output logic               busy,
   output logic               done,
   output logic [15:0]        instr_count
);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] LOAD   = 3'd2;
   localparam logic [2:0] ISSUE  = 3'd3;
   localparam logic [2:0] EXEC   = 3'd4;
   localparam logic [2:0] RETIRE = 3'd5;
   localparam logic [2:0] HALTED = 3'd6;
   localparam logic [2:0] PAUSE  = 3'd7;
   logic [2:0] state, nxt;
   logic [ADDR_W-1:0] pc;
   logic restart;
   assign mem_addr = pc;
   assign busy = state != IDLE && state != HALTED;
   assign done = state == HALTED;
   assign restart = (state == IDLE || state == HALTED) && run;
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE:   nxt = run ? FETCH : IDLE;
         FETCH:  nxt = LOAD;
         LOAD:   nxt = mem_data[INSTR_W-1 -: 3] == HALT_OPCODE ? HALTED : ISSUE;
         ISSUE:  nxt = w ? EXEC : ISSUE;
         // s is high only in the first EXEC cycle, so it doubles as the ignore-w flag
         EXEC:   nxt = !s && w ? RETIRE : EXEC;
`ifdef SINGLE_STEP_EN
         RETIRE: nxt = PAUSE;
         PAUSE:  nxt = step ? FETCH : PAUSE;
`else
         RETIRE: nxt = FETCH;
`endif
         HALTED: nxt = run ? FETCH : HALTED;
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pc <= '0;
         ir <= '0;
         s <= 1'b0;
         mem_rd <= 1'b0;
         instr_count <= '0;
      end else begin
         state <= nxt;
         mem_rd <= nxt == FETCH;
         s <= state == ISSUE && w;
         if (state == LOAD) ir <= mem_data;
         if (restart) begin
            pc <= '0;
            instr_count <= '0;
         end else if (state == RETIRE) begin
            pc <= pc + ADDR_W'(1);
            instr_count <= instr_count == 16'hFFFF ? instr_count : instr_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed tests with a bench-side instruction memory and control-FSM w model.
module tb_instr_sequencer;
   logic clk = 0, reset = 1, run = 1;
   logic [15:0] mem_data = 0;
   logic w;
   logic [7:0] mem_addr;
   logic mem_rd, s, busy, done;
   logic [15:0] ir, instr_count;
   logic [15:0] mem [256];
   logic wreg = 1, w_force0 = 0;
   int wcnt = 0, s_count = 0, checks = 0, fails = 0;
`ifdef SINGLE_STEP_EN
   logic step_auto = 1, step_pulse = 0, step;
   assign step = step_auto | step_pulse;
`endif
   instr_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .mem_data(mem_data), .w(w),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .mem_addr(mem_addr), .mem_rd(mem_rd), .ir(ir), .s(s), .busy(busy), .done(done),
      .instr_count(instr_count)
   );
   always #5 clk = ~clk;
   assign w = wreg & ~w_force0;
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
   // control FSM stand-in: drops w after s, raises it again a few cycles later
   always @(posedge clk) begin
      if (s) begin
         wreg <= 0;
         wcnt <= 4;
      end else if (wcnt > 1) wcnt <= wcnt - 1;
      else if (wcnt == 1) begin
         wcnt <= 0;
         wreg <= 1;
      end
   end
   always @(posedge clk) if (s) s_count++;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(input int max);
      for (int i = 0; i < max && !done; i++) tick();
   endtask
   task automatic pulse_run;
      run = 1;
      tick();
      run = 0;
   endtask
   task automatic test_reset;
      #3;
      checks++; if ({mem_rd, s, busy, done} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b expected 0000", {mem_rd, s, busy, done}); end
      checks++; if ({ir, instr_count, mem_addr} !== 40'h0) begin fails++; $display("FAIL reset_regs: got %h expected 0", {ir, instr_count, mem_addr}); end
      @(negedge clk);
      reset = 0;
      tick();
      run = 0;
      checks++; if (mem_rd !== 1 || mem_addr !== 8'h00 || busy !== 1) begin fails++; $display("FAIL first_fetch: got rd=%b addr=%h busy=%b expected 1 00 1", mem_rd, mem_addr, busy); end
   endtask
   task automatic test_program;
      int lat = 0;
      while (!s && lat < 20) begin tick(); lat++; end
      checks++; if (lat !== 3) begin fails++; $display("FAIL issue_latency: got %0d expected 3", lat); end
      checks++; if (ir !== 16'hD105) begin fails++; $display("FAIL ir_exec: got %h expected d105", ir); end
      wait_done(100);
      checks++; if (done !== 1 || busy !== 0) begin fails++; $display("FAIL prog_done: got done=%b busy=%b expected 1 0", done, busy); end
      checks++; if (s_count !== 1) begin fails++; $display("FAIL prog_s_pulses: got %0d expected 1", s_count); end
      checks++; if (mem_addr !== 8'h01 || instr_count !== 16'd1) begin fails++; $display("FAIL prog_pc_count: got pc=%h cnt=%0d expected 01 1", mem_addr, instr_count); end
      checks++; if (ir !== 16'hE000) begin fails++; $display("FAIL ir_halt: got %h expected e000", ir); end
   endtask
   task automatic test_w_stall;
      int base = s_count, viol = 0;
      w_force0 = 1;
      pulse_run();
      checks++; if (done !== 0 || mem_rd !== 1 || mem_addr !== 8'h00 || instr_count !== 16'd0) begin fails++; $display("FAIL restart: got done=%b rd=%b pc=%h cnt=%0d expected 0 1 00 0", done, mem_rd, mem_addr, instr_count); end
      repeat (20) begin tick(); if (s) viol++; end
      checks++; if (viol !== 0 || busy !== 1) begin fails++; $display("FAIL stall_s: got %0d pulses busy=%b expected 0 1", viol, busy); end
      w_force0 = 0;
      wait_done(100);
      checks++; if (s_count - base !== 1 || instr_count !== 16'd1 || done !== 1) begin fails++; $display("FAIL stall_release: got pulses=%0d cnt=%0d done=%b expected 1 1 1", s_count - base, instr_count, done); end
   endtask
   task automatic test_wrap;
      int base = s_count;
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
      pulse_run();
      for (int i = 0; i < 100 && instr_count == 0; i++) tick();
      mem[0] = 16'hE000;
      wait_done(5000);
      checks++; if (done !== 1 || mem_addr !== 8'h00 || instr_count !== 16'd256) begin fails++; $display("FAIL wrap: got done=%b pc=%h cnt=%0d expected 1 00 256", done, mem_addr, instr_count); end
      checks++; if (s_count - base !== 256) begin fails++; $display("FAIL wrap_pulses: got %0d expected 256", s_count - base); end
   endtask
   task automatic test_reset_exec;
      mem[0] = 16'h1000; mem[1] = 16'h1000; mem[2] = 16'hE000;
      pulse_run();
      for (int i = 0; i < 100 && !(s && instr_count == 1); i++) tick();
      checks++; if (s !== 1 || instr_count !== 16'd1 || mem_addr !== 8'h01) begin fails++; $display("FAIL pre_reset: got s=%b cnt=%0d pc=%h expected 1 1 01", s, instr_count, mem_addr); end
      reset = 1;
      #1;
      checks++; if (s !== 0 || mem_addr !== 8'h00 || instr_count !== 16'd0) begin fails++; $display("FAIL async_reset: got s=%b pc=%h cnt=%0d expected 0 00 0", s, mem_addr, instr_count); end
      checks++; if (busy !== 0 || mem_rd !== 0 || ir !== 16'h0) begin fails++; $display("FAIL async_reset_state: got busy=%b rd=%b ir=%h expected 0 0 0000", busy, mem_rd, ir); end
      @(negedge clk);
      reset = 0;
      tick();
      checks++; if (busy !== 0 || done !== 0) begin fails++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done); end
   endtask
`ifdef SINGLE_STEP_EN
   task automatic test_single_step;
      int base;
      repeat (10) tick();
      base = s_count;
      step_auto = 0;
      pulse_run();
      for (int i = 0; i < 100 && instr_count != 1; i++) tick();
      repeat (10) tick();
      checks++; if (busy !== 1 || done !== 0 || s_count - base !== 1 || mem_rd !== 0) begin fails++; $display("FAIL pause1: got busy=%b done=%b pulses=%0d rd=%b expected 1 0 1 0", busy, done, s_count - base, mem_rd); end
      step_pulse = 1; tick(); step_pulse = 0;
      for (int i = 0; i < 100 && instr_count != 2; i++) tick();
      repeat (10) tick();
      checks++; if (busy !== 1 || done !== 0 || s_count - base !== 2) begin fails++; $display("FAIL pause2: got busy=%b done=%b pulses=%0d expected 1 0 2", busy, done, s_count - base); end
      step_pulse = 1; tick(); step_pulse = 0;
      wait_done(100);
      checks++; if (done !== 1 || mem_addr !== 8'h02 || instr_count !== 16'd2) begin fails++; $display("FAIL step_done: got done=%b pc=%h cnt=%0d expected 1 02 2", done, mem_addr, instr_count); end
      step_auto = 1;
   endtask
`endif
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
      mem[0] = 16'hD105;
      test_reset();
      test_program();
      test_w_stall();
      test_wrap();
      test_reset_exec();
`ifdef SINGLE_STEP_EN
      test_single_step();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
